// File: rtl/bitop_result_fifo_if.sv
// Handshake bundle for bitop_result_fifo.
//   master : producer/consumer side (drives in_valid, in_data, out_ready)
//   slave  : FIFO side (drives out_valid, out_data, count, full, overflow)
// Optional: BITOP_RESULT_FIFO_POPCOUNT_EN adds out_ones (count of 1 bits in out_data).
interface bitop_result_fifo_if #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 8
);
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned OnesW = $clog2(Width + 1);

  logic             in_valid;
  logic [Width-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] out_data;
  logic [AddrW:0]   count;
  logic             full;
  logic             overflow;
`ifdef BITOP_RESULT_FIFO_POPCOUNT_EN
  logic [OnesW-1:0] out_ones;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, count, full, overflow, out_ones
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, count, full, overflow, out_ones
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, count, full, overflow
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, count, full, overflow
  );
`endif
endinterface

// File: rtl/bitop_result_fifo.sv
// Show-ahead FIFO buffering result words from a free-running bitwise stage.
// Pushes never stall the producer: when full without a pop, the word is dropped
// and the sticky overflow flag is raised.
// Ports:
//   clk_i    : clock, all state on posedge
//   rst_i    : asynchronous active-high reset
//   clear_i  : synchronous flush (beats push/pop, clears overflow)
//   bus_io   : bitop_result_fifo_if.slave (in_valid/in_data, out_valid/out_ready/out_data,
//              count, full, overflow[, out_ones])
// Optional build: define BITOP_RESULT_FIFO_POPCOUNT_EN to drive bus_io.out_ones.
// Depth must be a power of two >= 2 so pointers wrap by natural overflow.
module bitop_result_fifo #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  bitop_result_fifo_if.slave   bus_io
);
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             not_empty;
  logic             is_full;
  logic             push;
  logic             pop;
  logic [Width-1:0] out_data;

  always_comb begin
    not_empty = (count_q != '0);
    is_full   = (count_q == CntW'(Depth));
    pop       = not_empty && bus_io.out_ready;
    // A pop in the same cycle frees a slot, so full does not block that push.
    push      = bus_io.in_valid && (!is_full || pop);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (bus_io.in_valid && !push) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; visibility is gated by count_q.
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) mem_q[wr_ptr_q] <= bus_io.in_data;
  end

  always_comb begin
    out_data = not_empty ? mem_q[rd_ptr_q] : '0;
  end

  assign bus_io.out_valid = not_empty;
  assign bus_io.out_data  = out_data;
  assign bus_io.count     = count_q;
  assign bus_io.full      = is_full;
  assign bus_io.overflow  = overflow_q;

`ifdef BITOP_RESULT_FIFO_POPCOUNT_EN
  localparam int unsigned OnesW = $clog2(Width + 1);
  logic [OnesW-1:0] ones;

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      ones = ones + OnesW'(out_data[i]);
    end
  end

  assign bus_io.out_ones = ones;
`endif
endmodule

// File: tb/tb_bitop_result_fifo.sv
module tb_bitop_result_fifo;
  localparam int unsigned Width = 4;
  localparam int unsigned Depth = 8;

  logic clk;
  logic rst;
  logic clear;

  bitop_result_fifo_if #(.Width(Width), .Depth(Depth)) bus ();

  bitop_result_fifo #(.Width(Width), .Depth(Depth)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clear),
    .bus_io  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: plain queue of words plus sticky overflow bit.
  logic [Width-1:0] model_q[$];
  logic             model_ovf = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each clock edge from the inputs presented for that edge.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_q.delete();
        model_ovf = 1'b0;
      end else if (clear) begin
        model_q.delete();
        model_ovf = 1'b0;
      end else begin
        automatic bit do_pop   = (model_q.size() != 0) && (bus.out_ready === 1'b1);
        automatic bit was_full = (model_q.size() == Depth);
        automatic bit do_push  = (bus.in_valid === 1'b1) && (!was_full || do_pop);
        if (bus.in_valid === 1'b1 && !do_push) model_ovf = 1'b1;
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(bus.in_data);
      end
    end
  end

  // Compare every cycle, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      begin
        automatic logic [Width-1:0] exp_data = (model_q.size() != 0) ? model_q[0] : '0;
        chk("cmp_out_valid", 32'(bus.out_valid), 32'(model_q.size() != 0));
        chk("cmp_out_data", 32'(bus.out_data), 32'(exp_data));
        chk("cmp_count", 32'(bus.count), 32'(model_q.size()));
        chk("cmp_full", 32'(bus.full), 32'(model_q.size() == Depth));
        chk("cmp_overflow", 32'(bus.overflow), 32'(model_ovf));
`ifdef BITOP_RESULT_FIFO_POPCOUNT_EN
        chk("cmp_out_ones", 32'(bus.out_ones), 32'($countones(exp_data)));
`endif
      end
    end
  end

  // Present inputs for one clock edge; returns 2 time units after the edge.
  task automatic step(input logic iv, input logic [Width-1:0] d, input logic rdy,
                      input logic clr);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = rdy;
    clear         = clr;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst           = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #2;
    chk("reset_count", 32'(bus.count), 0);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_out_data", 32'(bus.out_data), 0);
    chk("reset_flags", {30'd0, bus.full, bus.overflow}, 0);
    rst = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);

    // Three pushes, consumer stalled.
    step(1'b1, 4'hA, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    step(1'b1, 4'h3, 1'b0, 1'b0);
    chk("t1_count", 32'(bus.count), 3);
    chk("t1_head", 32'(bus.out_data), 32'hA);
    chk("t1_valid", 32'(bus.out_valid), 1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Overrun while full.
    for (int i = 1; i <= 8; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    step(1'b1, 4'hF, 1'b0, 1'b0);
    chk("t2_full", 32'(bus.full), 1);
    chk("t2_overflow", 32'(bus.overflow), 1);
    chk("t2_count", 32'(bus.count), 8);
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain", 32'(bus.out_data), 32'(i));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    chk("t2_empty", 32'(bus.count), 0);
    chk("t2_ovf_sticky", 32'(bus.overflow), 1);
    step(1'b0, '0, 1'b1, 1'b0);  // pop on empty: no change
    chk("t2_empty_pop", 32'(bus.count), 0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("t2_ovf_cleared", 32'(bus.overflow), 0);

    // Push into full while popping.
    for (int i = 1; i <= 8; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    step(1'b1, 4'h9, 1'b1, 1'b0);
    chk("t3_count", 32'(bus.count), 8);
    chk("t3_head", 32'(bus.out_data), 2);
    chk("t3_overflow", 32'(bus.overflow), 0);
    for (int i = 2; i <= 9; i++) begin
      chk("t3_drain", 32'(bus.out_data), 32'(i));
      step(1'b0, '0, 1'b1, 1'b0);
    end

    // Streaming: one-cycle delay, occupancy 1, pointers wrap.
    step(1'b1, 4'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 4'(k), 1'b1, 1'b0);
      chk("t4_count", 32'(bus.count), 1);
      chk("t4_data", 32'(bus.out_data), 32'(k % 16));
    end
    step(1'b0, '0, 1'b1, 1'b0);

    // Clear with a simultaneous push.
    for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 3), 1'b0, 1'b0);
    chk("t5_pre_count", 32'(bus.count), 5);
    step(1'b1, 4'h7, 1'b0, 1'b1);
    chk("t5_count", 32'(bus.count), 0);
    chk("t5_valid", 32'(bus.out_valid), 0);
    chk("t5_overflow", 32'(bus.overflow), 0);
    chk("t5_data", 32'(bus.out_data), 0);

`ifdef BITOP_RESULT_FIFO_POPCOUNT_EN
    step(1'b1, 4'hB, 1'b0, 1'b0);
    chk("t6_ones_b", 32'(bus.out_ones), 3);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t6_ones_empty", 32'(bus.out_ones), 0);
`endif

    // Asynchronous reset mid-transfer, with overflow set.
    for (int i = 0; i < 9; i++) step(1'b1, 4'hC, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 0);
    chk("t6_rst_data", 32'(bus.out_data), 0);
    chk("t6_rst_count", 32'(bus.count), 0);
    chk("t6_rst_flags", {30'd0, bus.full, bus.overflow}, 0);
    step(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(99) < 70), 4'($urandom), ($urandom_range(99) < 45),
           ($urandom_range(99) < 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
